// File: rtl/nts_dispatcher_backend_if.sv
// Signal bundle between the dispatcher back end, the front-end packet buffer and the engines.
// The master modport is the back end; the slave modport is the surrounding front end/engines.
interface nts_dispatcher_backend_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ENGINES    = 4
);
    logic                  i_dispatch_packet_available;
    logic                  o_dispatch_packet_read_discard;
    logic [ADDR_WIDTH-1:0] i_dispatch_counter;
    logic [7:0]            i_dispatch_data_valid;
    logic                  i_dispatch_fifo_empty;
    logic                  o_dispatch_fifo_rd_en;
    logic [63:0]           i_dispatch_fifo_rd_data;
    logic [ENGINES-1:0]    i_engine_ready;
    logic [ENGINES-1:0]    o_engine_start;
    logic                  o_engine_word_valid;
    logic [63:0]           o_engine_data;
    logic [7:0]            o_engine_data_valid;
    logic                  o_engine_last;
    logic                  o_engine_error;

    modport master (
        input  i_dispatch_packet_available,
        output o_dispatch_packet_read_discard,
        input  i_dispatch_counter,
        input  i_dispatch_data_valid,
        input  i_dispatch_fifo_empty,
        output o_dispatch_fifo_rd_en,
        input  i_dispatch_fifo_rd_data,
        input  i_engine_ready,
        output o_engine_start,
        output o_engine_word_valid,
        output o_engine_data,
        output o_engine_data_valid,
        output o_engine_last,
        output o_engine_error
    );

    modport slave (
        output i_dispatch_packet_available,
        input  o_dispatch_packet_read_discard,
        output i_dispatch_counter,
        output i_dispatch_data_valid,
        output i_dispatch_fifo_empty,
        input  o_dispatch_fifo_rd_en,
        output i_dispatch_fifo_rd_data,
        output i_engine_ready,
        input  o_engine_start,
        input  o_engine_word_valid,
        input  o_engine_data,
        input  o_engine_data_valid,
        input  o_engine_last,
        input  o_engine_error
    );
endinterface

// File: rtl/nts_dispatcher_backend.sv
// Round-robin scheduler streaming buffered packets from the dispatcher front end to one of
// ENGINES NTS engines over a shared word bus, with timeout drop and truncation handling.
module nts_dispatcher_backend #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ENGINES    = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_areset,
    nts_dispatcher_backend_if.master bus,
    output logic [31:0]              o_dispatched_count,
    output logic [31:0]              o_dropped_count
);
    localparam int unsigned PTR_W  = (ENGINES > 1) ? $clog2(ENGINES) : 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StStream,
        StDrain,
        StDiscard,
        StHoldoff
    } state_e;

    state_e                state_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [WAIT_W-1:0]     wait_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic [ADDR_WIDTH-1:0] counter_q;
    logic [7:0]            mask_q;
    logic [ENGINES-1:0]    start_q;
    logic                  word_valid_q;
    logic                  last_q;
    logic                  discard_q;
    logic [31:0]           dispatched_q;
    logic [31:0]           dropped_q;

    logic                  grant_found;
    logic [PTR_W-1:0]      grant_idx;
    logic [31:0]           rr_idx;
    logic                  in_stream;
    logic                  trunc_now;
    logic                  last_issue;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hffff_ffff) ? v : v + 32'd1;
    endfunction

    // First ready engine strictly after the pointer, wrapping; the pointer itself is tried last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = '0;
        for (int unsigned k = 1; k <= ENGINES; k++) begin
            rr_idx = (32'(ptr_q) + k) % ENGINES;
            if (!grant_found && bus.i_engine_ready[PTR_W'(rr_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(rr_idx);
            end
        end
    end

    assign in_stream  = (state_q == StStream);
    assign trunc_now  = in_stream && bus.i_dispatch_fifo_empty;
    assign last_issue = (issued_q == {1'b0, counter_q});

    // Read strobe is qualified by empty so a truncating cycle never issues a read.
    assign bus.o_dispatch_fifo_rd_en = in_stream && !bus.i_dispatch_fifo_empty;

    // Read data arrives one cycle after its strobe and is forwarded directly onto the bus.
    assign bus.o_engine_start      = start_q;
    assign bus.o_engine_word_valid = word_valid_q;
    assign bus.o_engine_data       = word_valid_q ? bus.i_dispatch_fifo_rd_data : 64'd0;
    assign bus.o_engine_data_valid = !word_valid_q ? 8'h00 : (last_q ? mask_q : 8'hff);
    assign bus.o_engine_last       = last_q || trunc_now;
    assign bus.o_engine_error      = trunc_now;

    assign bus.o_dispatch_packet_read_discard = discard_q;
    assign o_dispatched_count = dispatched_q;
    assign o_dropped_count    = dropped_q;

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q      <= StIdle;
            ptr_q        <= PTR_W'(ENGINES - 1);
            wait_q       <= '0;
            issued_q     <= '0;
            counter_q    <= '0;
            mask_q       <= '0;
            start_q      <= '0;
            word_valid_q <= 1'b0;
            last_q       <= 1'b0;
            discard_q    <= 1'b0;
            dispatched_q <= '0;
            dropped_q    <= '0;
        end else begin
            start_q      <= '0;
            word_valid_q <= 1'b0;
            last_q       <= 1'b0;
            discard_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_dispatch_packet_available) begin
                        counter_q <= bus.i_dispatch_counter;
                        mask_q    <= bus.i_dispatch_data_valid;
                        wait_q    <= '0;
                        state_q   <= StSelect;
                    end
                end
                StSelect: begin
                    // A grant wins over an expiring timeout in the same cycle.
                    if (grant_found) begin
                        start_q  <= ENGINES'(1) << grant_idx;
                        ptr_q    <= grant_idx;
                        issued_q <= '0;
                        state_q  <= StStream;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        dropped_q <= sat_inc(dropped_q);
                        discard_q <= 1'b1;
                        state_q   <= StDiscard;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StStream: begin
                    if (bus.i_dispatch_fifo_empty) begin
                        dropped_q <= sat_inc(dropped_q);
                        discard_q <= 1'b1;
                        state_q   <= StDiscard;
                    end else begin
                        word_valid_q <= 1'b1;
                        issued_q     <= issued_q + 1'b1;
                        if (last_issue) begin
                            last_q  <= 1'b1;
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    dispatched_q <= sat_inc(dispatched_q);
                    discard_q    <= 1'b1;
                    state_q      <= StDiscard;
                end
                StDiscard: state_q <= StHoldoff;
                StHoldoff: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_nts_dispatcher_backend.sv
// Self-checking bench: front-end buffer model, bus monitor, and a packet-level reference model.
module tb_nts_dispatcher_backend;
    localparam int unsigned AW   = 8;
    localparam int unsigned E    = 4;
    localparam int unsigned TO   = 16;
    localparam int          MEMN = 1024;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  mask;
        logic        last;
        logic        err;
    } word_t;

    logic        i_clk = 1'b0;
    logic        i_areset = 1'b1;
    logic [31:0] dispatched;
    logic [31:0] dropped;

    nts_dispatcher_backend_if #(.ADDR_WIDTH(AW), .ENGINES(E)) bus ();

    nts_dispatcher_backend #(.ADDR_WIDTH(AW), .ENGINES(E), .TIMEOUT(TO)) dut (
        .i_clk              (i_clk),
        .i_areset           (i_areset),
        .bus                (bus),
        .o_dispatched_count (dispatched),
        .o_dropped_count    (dropped)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int errs  = 0;
    int exp_ptr  = E - 1;
    int exp_disp = 0;
    int exp_drop = 0;

    // Front-end buffer: a read strobe returns mem[rd_idx] on the next cycle.
    logic [63:0] mem [MEMN];
    int rd_idx = 0;
    int trunc_lim = -1;
    int trunc_base = 0;
    always @(posedge i_clk) begin
        if (bus.o_dispatch_fifo_rd_en) begin
            bus.i_dispatch_fifo_rd_data <= mem[rd_idx % MEMN];
            rd_idx <= rd_idx + 1;
        end
    end
    assign bus.i_dispatch_fifo_empty = (trunc_lim >= 0) && ((rd_idx - trunc_base) >= trunc_lim);

    // Monitor: records bus events tagged with the cycle they were seen in.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;
    word_t            words_q[$];
    int               word_cyc_q[$];
    int               start_cyc_q[$];
    logic [E-1:0]     start_val_q[$];
    int               disc_cyc_q[$];
    int               rd_cnt = 0;
    int               bus_junk = 0;
    word_t            mon_w;
    always @(negedge i_clk) begin
        if (bus.o_engine_word_valid) begin
            mon_w.data = bus.o_engine_data;
            mon_w.mask = bus.o_engine_data_valid;
            mon_w.last = bus.o_engine_last;
            mon_w.err  = bus.o_engine_error;
            words_q.push_back(mon_w);
            word_cyc_q.push_back(cyc);
        end else if (bus.o_engine_data !== 64'd0 || bus.o_engine_data_valid !== 8'h00) begin
            bus_junk++;
        end
        if (bus.o_engine_start !== '0) begin
            start_cyc_q.push_back(cyc);
            start_val_q.push_back(bus.o_engine_start);
        end
        if (bus.o_dispatch_fifo_rd_en) rd_cnt++;
        if (bus.o_dispatch_packet_read_discard) disc_cyc_q.push_back(cyc);
    end

    // Reference arbitration: first ready index after ptr, cyclic; -1 when nobody is ready.
    function automatic int rr_pick(input int ptr, input logic [E-1:0] rdy);
        for (int k = 1; k <= E; k++) begin
            if (((rdy >> ((ptr + k) % E)) & E'(1)) != '0) return (ptr + k) % E;
        end
        return -1;
    endfunction

    task automatic send_packet(input int cnt, input logic [7:0] mask, input int late_at,
                               input logic [E-1:0] late_ready, output int t0, output int base,
                               output bit ok);
        int n0;
        base = rd_idx;
        for (int i = 0; i <= cnt; i++) mem[(base + i) % MEMN] = {$urandom(), $urandom()};
        n0 = disc_cyc_q.size();
        @(negedge i_clk); #1;
        bus.i_dispatch_counter = AW'(cnt);
        bus.i_dispatch_data_valid = mask;
        bus.i_dispatch_packet_available = 1'b1;
        t0 = cyc;
        ok = 1'b0;
        for (int k = 0; k < 4000 && !ok; k++) begin
            @(negedge i_clk); #1;
            if (cyc - t0 == late_at) bus.i_engine_ready = late_ready;
            if (disc_cyc_q.size() > n0) ok = 1'b1;
        end
        bus.i_dispatch_packet_available = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_areset = 1'b1;
        bus.i_dispatch_packet_available = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        i_areset = 1'b0;
        exp_ptr = E - 1;
        exp_disp = 0;
        exp_drop = 0;
        @(negedge i_clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (bus.o_engine_start !== '0 || bus.o_engine_word_valid !== 1'b0) begin
            errs++; $display("FAIL reset_engine: start=%b wv=%b want 0", bus.o_engine_start,
                             bus.o_engine_word_valid);
        end
        tests++; if (bus.o_dispatch_fifo_rd_en !== 1'b0 || bus.o_dispatch_packet_read_discard !== 1'b0) begin
            errs++; $display("FAIL reset_fe: rd_en=%b discard=%b want 0", bus.o_dispatch_fifo_rd_en,
                             bus.o_dispatch_packet_read_discard);
        end
        tests++; if (bus.o_engine_last !== 1'b0 || bus.o_engine_error !== 1'b0) begin
            errs++; $display("FAIL reset_last: last=%b err=%b want 0", bus.o_engine_last,
                             bus.o_engine_error);
        end
        tests++; if (dispatched !== 32'd0 || dropped !== 32'd0) begin
            errs++; $display("FAIL reset_counts: disp=%0d drop=%0d want 0", dispatched, dropped);
        end
    endtask

    task automatic test_basic();
        int t0, base, s0, w0, d0, r0;
        bit ok;
        logic [7:0] em;
        bus.i_engine_ready = '1;
        s0 = start_cyc_q.size(); w0 = words_q.size(); d0 = disc_cyc_q.size(); r0 = rd_cnt;
        send_packet(3, 8'h0f, -1, '0, t0, base, ok);
        exp_ptr = 0; exp_disp++;
        tests++; if (!ok) begin errs++; $display("FAIL basic_done: got timeout want discard"); end
        tests++; if (start_cyc_q.size() - s0 != 1) begin
            errs++; $display("FAIL basic_start_cnt: got %0d want 1", start_cyc_q.size() - s0);
        end else begin
            tests++; if (start_val_q[s0] !== E'(1)) begin
                errs++; $display("FAIL basic_start: got %b want 0001", start_val_q[s0]);
            end
            tests++; if (start_cyc_q[s0] != t0 + 2) begin
                errs++; $display("FAIL basic_start_cyc: got %0d want %0d", start_cyc_q[s0], t0 + 2);
            end
        end
        tests++; if (rd_cnt - r0 != 4) begin
            errs++; $display("FAIL basic_rd_en: got %0d want 4", rd_cnt - r0);
        end
        tests++; if (words_q.size() - w0 != 4) begin
            errs++; $display("FAIL basic_words: got %0d want 4", words_q.size() - w0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                em = (i == 3) ? 8'h0f : 8'hff;
                tests++; if (words_q[w0+i] !== {mem[(base+i)%MEMN], em, (i == 3), 1'b0}) begin
                    errs++; $display("FAIL basic_word%0d: got %h want %h", i, words_q[w0+i],
                                     {mem[(base+i)%MEMN], em, (i == 3), 1'b0});
                end
            end
            tests++; if (word_cyc_q[w0] != t0 + 3) begin
                errs++; $display("FAIL basic_word_cyc: got %0d want %0d", word_cyc_q[w0], t0 + 3);
            end
        end
        tests++; if (disc_cyc_q.size() - d0 != 1 || disc_cyc_q[d0] != t0 + 7) begin
            errs++; $display("FAIL basic_discard: got %0d pulses want 1 at %0d", disc_cyc_q.size() - d0,
                             t0 + 7);
        end
        tests++; if (dispatched !== 32'(exp_disp) || dropped !== 32'(exp_drop)) begin
            errs++; $display("FAIL basic_counts: got %0d/%0d want %0d/%0d", dispatched, dropped,
                             exp_disp, exp_drop);
        end
    endtask

    task automatic test_round_robin();
        int t0, base, s0;
        bit ok;
        logic [E-1:0] want;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            bus.i_engine_ready = (p < 3) ? '1 : E'(2);
            want = (p < 3) ? (E'(1) << p) : E'(2);
            s0 = start_cyc_q.size();
            send_packet(int'($urandom_range(0, 5)), 8'hff, -1, '0, t0, base, ok);
            exp_disp++;
            tests++; if (!ok || start_val_q.size() - s0 != 1) begin
                errs++; $display("FAIL rr_pkt%0d: got %0d grants want 1", p, start_val_q.size() - s0);
            end else begin
                tests++; if (start_val_q[s0] !== want) begin
                    errs++; $display("FAIL rr_grant%0d: got %b want %b", p, start_val_q[s0], want);
                end
            end
        end
        exp_ptr = 1;
    endtask

    task automatic test_timeout();
        int t0, base, s0, w0, d0, r0;
        bit ok;
        bus.i_engine_ready = '0;
        s0 = start_cyc_q.size(); w0 = words_q.size(); d0 = disc_cyc_q.size(); r0 = rd_cnt;
        send_packet(2, 8'h01, -1, '0, t0, base, ok);
        exp_drop++;
        tests++; if (!ok || disc_cyc_q[d0] != t0 + TO + 1) begin
            errs++; $display("FAIL timeout_discard: ok=%0d got %0d want %0d", ok,
                             ok ? disc_cyc_q[d0] : -1, t0 + TO + 1);
        end
        tests++; if (start_cyc_q.size() != s0 || words_q.size() != w0 || rd_cnt != r0) begin
            errs++; $display("FAIL timeout_quiet: got starts=%0d words=%0d reads=%0d want 0",
                             start_cyc_q.size() - s0, words_q.size() - w0, rd_cnt - r0);
        end
        tests++; if (dispatched !== 32'(exp_disp) || dropped !== 32'(exp_drop)) begin
            errs++; $display("FAIL timeout_counts: got %0d/%0d want %0d/%0d", dispatched, dropped,
                             exp_disp, exp_drop);
        end
    endtask

    task automatic test_max_len();
        int t0, base, w0, r0, lasts;
        bit ok;
        logic [7:0] mask, em;
        mask = 8'($urandom_range(1, 255));
        bus.i_engine_ready = '1;
        w0 = words_q.size(); r0 = rd_cnt;
        send_packet(255, mask, -1, '0, t0, base, ok);
        exp_ptr = rr_pick(exp_ptr, '1); exp_disp++;
        tests++; if (!ok || rd_cnt - r0 != 256) begin
            errs++; $display("FAIL max_rd_en: got %0d want 256", rd_cnt - r0);
        end
        tests++; if (words_q.size() - w0 != 256) begin
            errs++; $display("FAIL max_words: got %0d want 256", words_q.size() - w0);
        end else begin
            lasts = 0;
            for (int i = 0; i < 256; i++) begin
                em = (i == 255) ? mask : 8'hff;
                if (words_q[w0+i].last) lasts++;
                tests++; if (words_q[w0+i] !== {mem[(base+i)%MEMN], em, (i == 255), 1'b0}) begin
                    errs++; $display("FAIL max_word%0d: got %h want %h", i, words_q[w0+i],
                                     {mem[(base+i)%MEMN], em, (i == 255), 1'b0});
                end
            end
            tests++; if (lasts != 1) begin errs++; $display("FAIL max_lasts: got %0d want 1", lasts); end
        end
    endtask

    task automatic test_truncation();
        int t0, base, w0, d0, r0;
        bit ok;
        bus.i_engine_ready = '1;
        trunc_base = rd_idx; trunc_lim = 2;
        w0 = words_q.size(); d0 = disc_cyc_q.size(); r0 = rd_cnt;
        send_packet(4, 8'h3f, -1, '0, t0, base, ok);
        trunc_lim = -1;
        exp_ptr = rr_pick(exp_ptr, '1); exp_drop++;
        tests++; if (!ok || rd_cnt - r0 != 2) begin
            errs++; $display("FAIL trunc_rd_en: got %0d want 2", rd_cnt - r0);
        end
        tests++; if (words_q.size() - w0 != 2) begin
            errs++; $display("FAIL trunc_words: got %0d want 2", words_q.size() - w0);
        end else begin
            tests++; if (words_q[w0] !== {mem[base%MEMN], 8'hff, 1'b0, 1'b0}) begin
                errs++; $display("FAIL trunc_word0: got %h want %h", words_q[w0],
                                 {mem[base%MEMN], 8'hff, 1'b0, 1'b0});
            end
            tests++; if (words_q[w0+1] !== {mem[(base+1)%MEMN], 8'hff, 1'b1, 1'b1}) begin
                errs++; $display("FAIL trunc_word1: got %h want %h", words_q[w0+1],
                                 {mem[(base+1)%MEMN], 8'hff, 1'b1, 1'b1});
            end
        end
        tests++; if (disc_cyc_q.size() - d0 != 1 || disc_cyc_q[d0] != t0 + 5) begin
            errs++; $display("FAIL trunc_discard: got %0d pulses want 1 at %0d", disc_cyc_q.size() - d0,
                             t0 + 5);
        end
        tests++; if (dispatched !== 32'(exp_disp) || dropped !== 32'(exp_drop)) begin
            errs++; $display("FAIL trunc_counts: got %0d/%0d want %0d/%0d", dispatched, dropped,
                             exp_disp, exp_drop);
        end
    endtask

    task automatic test_reset_mid_stream();
        int t0, base, s0, d0, r0;
        bit ok;
        bus.i_engine_ready = '1;
        d0 = disc_cyc_q.size(); r0 = rd_cnt;
        for (int i = 0; i < 40; i++) mem[(rd_idx + i) % MEMN] = {$urandom(), $urandom()};
        @(negedge i_clk); #1;
        bus.i_dispatch_counter = AW'(30);
        bus.i_dispatch_data_valid = 8'hff;
        bus.i_dispatch_packet_available = 1'b1;
        for (int k = 0; k < 200 && (rd_cnt - r0) < 5; k++) begin @(negedge i_clk); #1; end
        tests++; if (rd_cnt - r0 < 5) begin
            errs++; $display("FAIL midrst_stream: got %0d reads want >=5", rd_cnt - r0);
        end
        i_areset = 1'b1;
        bus.i_dispatch_packet_available = 1'b0;
        @(negedge i_clk); #1;
        tests++; if ({bus.o_dispatch_fifo_rd_en, bus.o_engine_word_valid, bus.o_engine_start,
                     bus.o_engine_last, bus.o_engine_error, bus.o_dispatch_packet_read_discard} !== '0
                     || bus.o_engine_data !== 64'd0 || dispatched !== 32'd0 || dropped !== 32'd0) begin
            errs++; $display("FAIL midrst_outputs: rd=%b wv=%b st=%b last=%b err=%b disc=%b want 0",
                             bus.o_dispatch_fifo_rd_en, bus.o_engine_word_valid, bus.o_engine_start,
                             bus.o_engine_last, bus.o_engine_error, bus.o_dispatch_packet_read_discard);
        end
        repeat (3) @(negedge i_clk);
        #1;
        tests++; if (disc_cyc_q.size() != d0) begin
            errs++; $display("FAIL midrst_no_discard: got %0d pulses want 0", disc_cyc_q.size() - d0);
        end
        i_areset = 1'b0;
        exp_ptr = E - 1; exp_disp = 0; exp_drop = 0;
        @(negedge i_clk); #1;
        s0 = start_val_q.size();
        send_packet(1, 8'h07, -1, '0, t0, base, ok);
        exp_ptr = 0; exp_disp++;
        tests++; if (!ok || start_val_q.size() - s0 != 1 || start_val_q[s0] !== E'(1)) begin
            errs++; $display("FAIL midrst_grant: got %0d grants first=%b want 1 x 0001",
                             start_val_q.size() - s0, (start_val_q.size() > s0) ? start_val_q[s0] : '0);
        end
    endtask

    task automatic test_late_ready();
        int t0, base, s0, d0, cnt;
        bit ok;
        cnt = 2;
        bus.i_engine_ready = '0;
        s0 = start_cyc_q.size(); d0 = disc_cyc_q.size();
        send_packet(cnt, 8'h80, TO, '1, t0, base, ok);
        exp_ptr = rr_pick(exp_ptr, '1); exp_disp++;
        tests++; if (!ok || start_cyc_q.size() - s0 != 1) begin
            errs++; $display("FAIL late_grant: got %0d grants want 1", start_cyc_q.size() - s0);
        end else begin
            tests++; if (start_cyc_q[s0] != t0 + TO + 1 || start_val_q[s0] !== (E'(1) << exp_ptr)) begin
                errs++; $display("FAIL late_grant_cyc: got %0d/%b want %0d/%b", start_cyc_q[s0],
                                 start_val_q[s0], t0 + TO + 1, E'(1) << exp_ptr);
            end
        end
        tests++; if (disc_cyc_q.size() - d0 != 1 || disc_cyc_q[d0] != t0 + TO + cnt + 3) begin
            errs++; $display("FAIL late_discard: want 1 pulse at %0d", t0 + TO + cnt + 3);
        end
        tests++; if (dispatched !== 32'(exp_disp) || dropped !== 32'(exp_drop)) begin
            errs++; $display("FAIL late_counts: got %0d/%0d want %0d/%0d", dispatched, dropped,
                             exp_disp, exp_drop);
        end
    endtask

    task automatic test_random();
        int t0, base, s0, w0, d0, cnt, g, exp_nw, exp_disc;
        bit ok;
        logic [7:0] mask, em;
        logic [E-1:0] rdy;
        for (int p = 0; p < 30; p++) begin
            cnt  = int'($urandom_range(0, 12));
            mask = 8'($urandom_range(1, 255));
            rdy  = E'($urandom_range(0, (1 << E) - 1));
            bus.i_engine_ready = rdy;
            g = rr_pick(exp_ptr, rdy);
            s0 = start_cyc_q.size(); w0 = words_q.size(); d0 = disc_cyc_q.size();
            send_packet(cnt, mask, -1, '0, t0, base, ok);
            if (g >= 0) begin
                exp_ptr = g; exp_disp++; exp_nw = cnt + 1; exp_disc = t0 + cnt + 4;
            end else begin
                exp_drop++; exp_nw = 0; exp_disc = t0 + TO + 1;
            end
            tests++; if (!ok || disc_cyc_q[d0] != exp_disc) begin
                errs++; $display("FAIL rand%0d_discard: ok=%0d want cycle %0d", p, ok, exp_disc);
            end
            tests++; if (start_val_q.size() - s0 != ((g >= 0) ? 1 : 0)) begin
                errs++; $display("FAIL rand%0d_grants: got %0d want %0d", p, start_val_q.size() - s0,
                                 (g >= 0) ? 1 : 0);
            end else if (g >= 0) begin
                tests++; if (start_val_q[s0] !== (E'(1) << g)) begin
                    errs++; $display("FAIL rand%0d_engine: got %b want %b", p, start_val_q[s0],
                                     E'(1) << g);
                end
            end
            tests++; if (words_q.size() - w0 != exp_nw) begin
                errs++; $display("FAIL rand%0d_words: got %0d want %0d", p, words_q.size() - w0, exp_nw);
            end else begin
                for (int i = 0; i < exp_nw; i++) begin
                    em = (i == cnt) ? mask : 8'hff;
                    tests++; if (words_q[w0+i] !== {mem[(base+i)%MEMN], em, (i == cnt), 1'b0}) begin
                        errs++; $display("FAIL rand%0d_word%0d: got %h want %h", p, i, words_q[w0+i],
                                         {mem[(base+i)%MEMN], em, (i == cnt), 1'b0});
                    end
                end
            end
            tests++; if (dispatched !== 32'(exp_disp) || dropped !== 32'(exp_drop)) begin
                errs++; $display("FAIL rand%0d_counts: got %0d/%0d want %0d/%0d", p, dispatched,
                                 dropped, exp_disp, exp_drop);
            end
        end
    endtask

    initial begin
        bus.i_dispatch_packet_available = 1'b0;
        bus.i_dispatch_counter = '0;
        bus.i_dispatch_data_valid = '0;
        bus.i_engine_ready = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_max_len();
        test_truncation();
        test_reset_mid_stream();
        test_late_ready();
        test_random();
        tests++; if (bus_junk != 0) begin
            errs++; $display("FAIL idle_bus_zero: got %0d non-zero idle cycles want 0", bus_junk);
        end
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
